// File: rtl/maxpool_1d_stream_if.sv
// maxpool_1d_stream_if: input and pooled-output valid/ready streams; MAXPOOL_LAST_EN adds y_last
interface maxpool_1d_stream_if #(parameter int W = 16);
    logic signed [W-1:0] x_data;
    logic                x_valid;
    logic                x_ready;
    logic signed [W-1:0] y_data;
    logic                y_valid;
    logic                y_ready;
`ifdef MAXPOOL_LAST_EN
    logic                y_last;
    modport master (output x_data, x_valid, y_ready, input x_ready, y_data, y_valid, y_last);
    modport slave  (input x_data, x_valid, y_ready, output x_ready, y_data, y_valid, y_last);
`else
    modport master (output x_data, x_valid, y_ready, input x_ready, y_data, y_valid);
    modport slave  (input x_data, x_valid, y_ready, output x_ready, y_data, y_valid);
`endif
endinterface

// File: rtl/maxpool_1d_stream.sv
// maxpool_1d_stream: streaming 1-D signed max-pool, window/stride P over N-word vectors; MAXPOOL_LAST_EN adds y_last
module maxpool_1d_stream #(
    parameter int N = 27,
    parameter int P = 3,
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    maxpool_1d_stream_if.slave   s
);
    localparam int WC = (P > 1) ? $clog2(P) : 1;
    localparam int VC = (N > 1) ? $clog2(N) : 1;
    logic [WC-1:0]       win_cnt;
    logic [VC-1:0]       vec_cnt;
    logic signed [W-1:0] run_max;
    logic signed [W-1:0] cand;
    logic signed [W-1:0] y_data_q;
    logic                y_valid_q;
    logic                rdy;
    logic                xfer;
    logic                vec_end;
    logic                close;
`ifdef MAXPOOL_LAST_EN
    logic                y_last_q;
    assign s.y_last = y_last_q;
`endif
    assign s.x_ready = rdy;
    assign s.y_data  = y_data_q;
    assign s.y_valid = y_valid_q;
    // handshake, window-close detect and the max including the word being accepted
    always_comb begin
        rdy     = reset & (~y_valid_q | s.y_ready);
        xfer    = s.x_valid & rdy;
        vec_end = vec_cnt == VC'(N - 1);
        close   = (win_cnt == WC'(P - 1)) | vec_end;
        cand    = (win_cnt == '0 || s.x_data > run_max) ? s.x_data : run_max;
    end
    // window/vector counters and running max advance only on accepted words
    always_ff @(posedge clk) begin
        if (!reset) begin
            win_cnt <= '0;
            vec_cnt <= '0;
            run_max <= '0;
        end else if (xfer) begin
            run_max <= cand;
            win_cnt <= close ? '0 : win_cnt + 1'b1;
            vec_cnt <= vec_end ? '0 : vec_cnt + 1'b1;
        end
    end
    // output register loads on window close, otherwise drains on consumption
    always_ff @(posedge clk) begin
        if (!reset) begin
            y_data_q  <= '0;
            y_valid_q <= 1'b0;
`ifdef MAXPOOL_LAST_EN
            y_last_q  <= 1'b0;
`endif
        end else if (xfer && close) begin
            y_data_q  <= cand;
            y_valid_q <= 1'b1;
`ifdef MAXPOOL_LAST_EN
            y_last_q  <= vec_end;
`endif
        end else if (y_valid_q && s.y_ready) begin
            y_valid_q <= 1'b0;
        end
    end
endmodule

// File: doc/maxpool_1d_stream.md
Name: maxpool_1d_stream

Overview:
- Streaming 1-D max-pooling stage placed directly downstream of the conv_X_F_W_1 blocks.
- Consumes the conv output stream of N = X-F+1 ReLU'd signed words per vector over a valid/ready handshake.
- Emits one signed maximum per non-overlapping window of P words (stride = P).
- Feeds the next conv/FC layer using the same handshake.

Parameters:
- N, 27, input words per vector (default matches the conv 32/6 output count).
- P, 3, pool window size and stride; P >= 1, P <= N.
- W, 16, data width (signed two's complement).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- x_data  input  W  signed input word.
- x_valid  input  1  upstream word valid.
- x_ready  output  1  block can accept x_data this cycle.
- y_data  output  W  signed pooled result (registered).
- y_valid  output  1  y_data valid.
- y_ready  input  1  downstream accepts y_data.
- y_last  output  1  present only with MAXPOOL_LAST_EN.

Behaviour:
- Reset: sampled on the rising edge of clk while reset==0; overrides all other activity.
  - y_valid=0, y_data=0, running max=0, win_cnt=0, vec_cnt=0, y_last=0.
  - x_ready=0 combinationally while reset==0.
  - A reset mid-window discards the partial maximum and any un-accepted output.
- Handshakes:
  - Input transfer: x_valid & x_ready.
  - Output transfer: y_valid & y_ready.
  - x_ready = reset & (~y_valid | y_ready). The output register frees in the same cycle it is consumed, giving full throughput of 1 word/cycle.
- Counters:
  - win_cnt counts 0..P-1 within the current window.
  - vec_cnt counts 0..N-1 within the vector.
  - Both advance only on an input transfer.
  - Window close = win_cnt==P-1 OR vec_cnt==N-1.
  - On close: win_cnt<=0. vec_cnt<=0 if vec_cnt==N-1, else vec_cnt+1.
- Running max (signed compare):
  - On a transfer with win_cnt==0: max<=x_data.
  - On other transfers: max<=(x_data>max)?x_data:max. On ties the value is unchanged.
- Output register:
  - On the window-close transfer: y_data<=max(current max, x_data) (x_data alone if P==1), and y_valid<=1.
  - Else if an output transfer occurs: y_valid<=0, and y_data holds its last value.
  - Simultaneous output transfer and window close in the same cycle: the new result loads and y_valid stays 1.
- Latency: y_valid rises 1 cycle after the window-closing word is accepted.
- Trailing partial window: if N mod P != 0, the last window closes at vec_cnt==N-1 and emits the max of the remaining N mod P words.
  - Outputs per vector = ceil(N/P); default 9.
- Backpressure:
  - While y_valid=1 and y_ready=0: x_ready=0, and all state and counters hold.
  - y_data and y_valid must remain stable until accepted.
- Vectors run back-to-back; after vec_cnt wraps, the next accepted word starts a new vector with no idle cycle.
- Values pass through unchanged: no saturation and no width growth.
- States (implicit in win_cnt and y_valid):
  - ACCUM: y_valid=0, or y_valid=1 & y_ready=1.
  - HOLD: y_valid=1 & y_ready=0.

Optional Feature:
- MAXPOOL_LAST_EN defined:
  - Adds output y_last, registered alongside y_data.
  - y_last=1 for the output whose window closed at vec_cnt==N-1, else 0.
  - Reset value 0; held stable with y_data under backpressure.
- Undefined: no y_last port; behaviour is otherwise identical.

Test Plan:
- Reset (reset=0 for 2 cycles), then stream 1,5,3, 2,2,2, ... (N=27,P=3), y_ready=1 throughout -> outputs 5,2,...
  - Each output appears 1 cycle after its 3rd input.
  - x_ready stays 1 and 9 outputs are produced.
- Signed compare: window -4,-1,-7 -> y_data=-1. Window -32768,32767,0 -> y_data=32767.
- Backpressure: hold y_ready=0 for 5 cycles after the first output (value 5).
  - Required: x_ready=0, y_data=5 and y_valid=1 stable, no input consumed.
  - On release: the next window continues correctly.
- N=10, P=4, inputs 1..10 -> outputs 4,8,10, with 10 emitted from a 2-word partial window.
  - With MAXPOOL_LAST_EN: y_last=1 only on 10.
- Reset mid-window: after inputs 9,9, reset=0 for 1 cycle, then inputs 1,2,3 -> y_data=3 (stale 9 discarded), and y_valid=0 during reset.
- Back-to-back vectors with y_ready toggling 1,0,1,0 -> 18 outputs in order, with no loss or duplication at the vector boundary.
